// File: rtl/shared_pkg.sv
// Completer FSM states, word-address offset and error-cause helper
// used by the APB RAM completer.
package shared_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } cmp_state_e;

  localparam int MEM_ADDR_LSB = 2;

  // Bit 2: read carrying strobes, bit 1: misaligned, bit 0: out of range.
  function automatic logic [2:0] err_cause(input logic oob,
                                           input logic [1:0] addr_lo,
                                           input logic is_write,
                                           input logic strb_any);
    return {(~is_write) & strb_any, |addr_lo, oob};
  endfunction

endpackage

// File: rtl/apb_defines.svh
// Default bus widths shared by the APB completer sources.
`ifndef APB_DEFINES_SVH
`define APB_DEFINES_SVH

`define APB_DATA_W 32
`define APB_ADDR_W 32
`define APB_PROT_W 3

`endif

// File: rtl/apb_ram_mem.sv
// Byte-lane RAM: synchronous strobed write, asynchronous read. Contents are
// not reset.
module apb_ram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8,
  parameter int STRB_W = DATA_W/8
) (
  input  logic              PCLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge PCLK) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_ram_completer.sv
// APB4 completer in front of a byte-strobed RAM. Define APB_SLV_WAIT_EN to
// insert WAIT_CYCLES wait states per transfer; otherwise every transfer is zero-wait.
`include "apb_defines.svh"

module apb_ram_completer
  import shared_pkg::*;
#(
  parameter int APB_DATA_WIDTH = `APB_DATA_W,
  parameter int APB_ADDR_WIDTH = `APB_ADDR_W,
  parameter int APB_STRB_WIDTH = APB_DATA_WIDTH/8,
  parameter int APB_PROT_WIDTH = `APB_PROT_W,
  parameter int MEM_DEPTH      = 256,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_STRB_WIDTH-1:0] PSTRB,
  input  logic [APB_PROT_WIDTH-1:0] PPROT,
  output logic                      PREADY,
  output logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic                      PSLVERR
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  cmp_state_e state_q, state_d;
  logic capture, done_ld;

  logic                      write_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic [APB_STRB_WIDTH-1:0] strb_q;
  logic [APB_PROT_WIDTH-1:0] prot_unused;  // captured only; no effect on access

  logic                      cur_write;
  logic [APB_ADDR_WIDTH-1:0] cur_addr;
  logic [APB_STRB_WIDTH-1:0] cur_strb;
  logic [IDX_W-1:0]          idx;
  logic                      oob, err, mem_we;
  logic [APB_DATA_WIDTH-1:0] rdata;

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  // In S_IDLE a zero-wait transfer must be decoded from the live SETUP inputs.
  always_comb begin
    cur_write = write_q;
    cur_addr  = addr_q;
    cur_strb  = strb_q;
    if (state_q == S_IDLE) begin
      cur_write = PWRITE;
      cur_addr  = PADDR;
      cur_strb  = PSTRB;
    end
  end

  assign idx    = cur_addr[MEM_ADDR_LSB +: IDX_W];
  assign oob    = |cur_addr[APB_ADDR_WIDTH-1:MEM_ADDR_LSB+IDX_W];
  assign err    = |err_cause(oob, cur_addr[1:0], cur_write, |cur_strb);
  assign mem_we = (state_q == S_DONE) && write_q && !err;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    done_ld = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          capture = 1'b1;
`ifdef APB_SLV_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
            done_ld = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_CYCLES[3:0];
          end
`else
          state_d = S_DONE;
          done_ld = 1'b1;
`endif
        end
      end
`ifdef APB_SLV_WAIT_EN
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          done_ld = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
`ifdef APB_SLV_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_unused <= '0;
      PREADY      <= 1'b0;
      PRDATA      <= '0;
      PSLVERR     <= 1'b0;
    end else begin
      if (capture) begin
        write_q     <= PWRITE;
        addr_q      <= PADDR;
        wdata_q     <= PWDATA;
        strb_q      <= PSTRB;
        prot_unused <= PPROT;
      end
      PREADY  <= done_ld;
      PSLVERR <= done_ld && err;
      PRDATA  <= (done_ld && !err && !cur_write) ? rdata : '0;
    end
  end

  apb_ram_mem #(
    .DATA_W (APB_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W),
    .STRB_W (APB_STRB_WIDTH)
  ) u_mem (
    .PCLK  (PCLK),
    .we    (mem_we),
    .waddr (addr_q[MEM_ADDR_LSB +: IDX_W]),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (idx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_apb_ram_completer.sv
// Directed bench for apb_ram_completer with a reference memory and expected-response queue.
module tb_apb_ram_completer;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_W = 3;
`else
  localparam int EXP_W = 0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  apb_ram_completer #(
    .APB_DATA_WIDTH (32),
    .APB_ADDR_WIDTH (32),
    .APB_STRB_WIDTH (4),
    .APB_PROT_WIDTH (3),
    .MEM_DEPTH      (256),
    .WAIT_CYCLES    (3)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PPROT   (PPROT),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  int          n_vec = 0;
  int          n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    exp_t e, got;
    int   waits;
    bit   done;
    e.rd    = !wr;
    e.err   = (addr >= 32'h400) || (addr[1:0] != 2'b00) || (!wr && strb != 4'h0);
    e.data  = '0;
    e.waits = EXP_W;
    if (!e.err && !wr) e.data = ref_mem[addr[9:2]];
    if (!e.err && wr)
      for (int i = 0; i < 4; i++)
        if (strb[i]) ref_mem[addr[9:2]][i*8 +: 8] = wdata[i*8 +: 8];
    sb.push_back(e);

    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = addr; PWDATA = wdata; PSTRB = strb; PPROT = 3'b010;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge PCLK);
      if (PREADY) done = 1'b1;
      else begin
        waits++;
        check({tag, "_idle_outs"}, {31'd0, PSLVERR, PRDATA}, 64'd0);
      end
    end
    got = sb.pop_front();
    check({tag, "_ready"}, {63'd0, done}, 64'd1);
    if (done) begin
      check({tag, "_waits"}, waits, got.waits);
      check({tag, "_pslverr"}, {63'd0, PSLVERR}, {63'd0, got.err});
      if (got.rd || got.err) check({tag, "_prdata"}, {32'd0, PRDATA}, {32'd0, got.data});
    end
  endtask

  initial begin
    bit saw;
    PRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check("reset_outs", {31'd0, PREADY, PSLVERR, PRDATA}, 64'd0);
    PRESETn = 1'b1;

    // PENABLE without SETUP in idle
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h10;
    saw = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      if (PREADY) saw = 1'b1;
    end
    check("penable_only", {63'd0, saw}, 64'd0);
    go_idle();

    xfer("wr_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xfer("rd_10", 1'b0, 32'h10, 32'h0, 4'h0);
    go_idle();

    xfer("pre_20", 1'b1, 32'h20, 32'h11223344, 4'hF);
    go_idle();
    xfer("strb_20", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    go_idle();
    xfer("rd_20", 1'b0, 32'h20, 32'h0, 4'h0);
    check("rd_20_literal", {32'd0, PRDATA}, 64'h11BB33DD);
    go_idle();

    xfer("pre_00", 1'b1, 32'h00, 32'hCAFE0000, 4'hF);
    go_idle();
    xfer("err_wr_400", 1'b1, 32'h400, 32'h12345678, 4'hF);
    go_idle();
    xfer("rd_00", 1'b0, 32'h00, 32'h0, 4'h0);
    go_idle();
    xfer("err_rd_13", 1'b0, 32'h13, 32'h0, 4'h0);
    go_idle();
    xfer("err_rd_strb", 1'b0, 32'h10, 32'h0, 4'h3);
    go_idle();
    xfer("wr0_strb", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    xfer("rd_10_after_noop", 1'b0, 32'h10, 32'h0, 4'h0);
    go_idle();

    // back-to-back writes then reads, no idle cycles
    xfer("b2b_wr_50", 1'b1, 32'h50, 32'h0A0B0C0D, 4'hF);
    xfer("b2b_wr_54", 1'b1, 32'h54, 32'h01020304, 4'hF);
    xfer("b2b_rd_50", 1'b0, 32'h50, 32'h0, 4'h0);
    xfer("b2b_rd_54", 1'b0, 32'h54, 32'h0, 4'h0);
    go_idle();

    // reset during the completing cycle of a write
    xfer("pre_30", 1'b1, 32'h30, 32'h00000055, 4'hF);
    go_idle();
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h30; PWDATA = 32'h00000099; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 40 && !saw; c++) begin
      @(negedge PCLK);
      if (PREADY) saw = 1'b1;
    end
    check("rst_mid_ready_seen", {63'd0, saw}, 64'd1);
    #1 PRESETn = 1'b0;
    #1;
    check("rst_mid_outs", {31'd0, PREADY, PSLVERR, PRDATA}, 64'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    xfer("rd_30_after_rst", 1'b0, 32'h30, 32'h0, 4'h0);
    go_idle();

`ifdef APB_SLV_WAIT_EN
    // initiator abort during wait states
    xfer("pre_40", 1'b1, 32'h40, 32'h00000066, 4'hF);
    go_idle();
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h40; PWDATA = 32'h00000077; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      if (PREADY) saw = 1'b1;
    end
    check("abort_no_ready", {63'd0, saw}, 64'd0);
    xfer("rd_40_after_abort", 1'b0, 32'h40, 32'h0, 4'h0);
    go_idle();
`endif

    repeat (2) @(posedge PCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
